// File: rtl/sequence_det_param.sv
// Parametrised Mealy serial-pattern detector.
// The pattern is SEQ_LEN bits wide and is loaded at run time. Overlapping or
// non-overlapping detection is selected at run time, and en gates every bit.
// Optional feature macro SEQ_DET_COUNT_EN adds the saturating det_count output.
//
// state (r_fill)     | meaning
// 0 .. SEQ_LEN-2     | history only partly filled, so no match is possible
// SEQ_LEN-1          | armed: det = {r_hist, inp} == r_pat
module sequence_det_param #(
    parameter int                 SEQ_LEN = 3,
    parameter logic [SEQ_LEN-1:0] DEF_PAT = SEQ_LEN'(1),
    parameter int                 COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp,
    input  logic               en,
    input  logic               overlap,
    input  logic               load,
    input  logic [SEQ_LEN-1:0] pattern,
    output logic               det
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [COUNT_W-1:0] det_count
`endif
);
    localparam int                FILL_W    = $clog2(SEQ_LEN) + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN - 1);

    if (SEQ_LEN < 2 || SEQ_LEN > 32 || COUNT_W < 1) begin : g_bad_param
        $error("sequence_det_param: illegal parameter value");
    end

    logic [SEQ_LEN-1:0] r_pat;
    logic [SEQ_LEN-1:0] w_pat_nxt;
    logic [SEQ_LEN-2:0] r_hist;
    logic [SEQ_LEN-2:0] w_hist_nxt;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic [SEQ_LEN-1:0] w_win;
    logic               w_match;
    logic               w_det;

    // The newest bit completes the window, so the match is visible in the same cycle.
    assign w_win   = {r_hist, inp};
    assign w_match = (r_fill == FILL_FULL) && (w_win == r_pat);
    assign w_det   = reset && en && !load && w_match;
    assign det     = w_det;

    // Next-state logic: load beats en, and a non-overlap match consumes the history.
    always_comb begin
        w_pat_nxt  = r_pat;
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (load) begin
            w_pat_nxt  = pattern;
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (en) begin
            if (w_match && !overlap) begin
                w_fill_nxt = '0;
            end else begin
                w_hist_nxt = w_win[SEQ_LEN-2:0];
                w_fill_nxt = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
            end
        end
    end

    // State registers; reset discards all partial progress immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat  <= DEF_PAT;
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_pat  <= w_pat_nxt;
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [COUNT_W-1:0] r_count;

    // Saturating match counter; it is cleared by load and by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (w_det && (r_count != '1)) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign det_count = r_count;
`endif

endmodule

// File: tb/tb_sequence_det_param.sv
// Bench for sequence_det_param. A 3-bit instance and a 4-bit instance share
// the serial stimulus. Each instance is checked against a queue-based model,
// and directed literal expectations are also checked.
module tb_sequence_det_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       inp;
    logic       en;
    logic       overlap;
    logic       load;
    logic [2:0] p3;
    logic [3:0] p4;
    logic       det3;
    logic       det4;
`ifdef SEQ_DET_COUNT_EN
    logic [3:0] cnt3;
    logic [3:0] cnt4;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sequence_det_param #(.SEQ_LEN(3), .DEF_PAT(3'b001), .COUNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .inp(inp), .en(en), .overlap(overlap),
        .load(load), .pattern(p3), .det(det3)
`ifdef SEQ_DET_COUNT_EN
        , .det_count(cnt3)
`endif
    );

    sequence_det_param #(.SEQ_LEN(4), .DEF_PAT(4'b0011), .COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .inp(inp), .en(en), .overlap(overlap),
        .load(load), .pattern(p4), .det(det4)
`ifdef SEQ_DET_COUNT_EN
        , .det_count(cnt4)
`endif
    );

    // Model state: accepted bits since the last clear (oldest first), the active pattern, and the match count.
    bit       q3[$];
    bit       q4[$];
    bit [3:0] mp3;
    bit [3:0] mp4;
    int       c3;
    int       c4;

    function automatic bit mmatch(input bit q[$], input int len, input bit [3:0] pat, input bit b);
        int v;
        if (q.size() < len - 1) return 1'b0;
        v = 0;
        for (int k = q.size() - (len - 1); k < q.size(); k++) v = (v << 1) | int'(q[k]);
        v = (v << 1) | int'(b);
        return v == int'(pat);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each accepted clock edge.
    always @(posedge clk or negedge reset) begin
        bit m3, m4;
        if (!reset) begin
            q3.delete(); q4.delete();
            mp3 = 4'b0001; mp4 = 4'b0011;
            c3 = 0; c4 = 0;
        end else if (load) begin
            q3.delete(); q4.delete();
            mp3 = {1'b0, p3}; mp4 = p4;
            c3 = 0; c4 = 0;
        end else if (en) begin
            m3 = mmatch(q3, 3, mp3, inp);
            m4 = mmatch(q4, 4, mp4, inp);
            if (m3 && c3 < 15) c3++;
            if (m4 && c4 < 15) c4++;
            if (m3 && !overlap) q3.delete(); else q3.push_back(inp);
            if (m4 && !overlap) q4.delete(); else q4.push_back(inp);
            while (q3.size() > 8) void'(q3.pop_front());
            while (q4.size() > 8) void'(q4.pop_front());
        end
    end

    // Compare the DUT against the model at every negedge.
    always @(negedge clk) begin
        if (!reset) begin
            check("det3_in_reset", int'(det3), 0);
            check("det4_in_reset", int'(det4), 0);
        end else begin
            check("det3", int'(det3), int'(en && !load && mmatch(q3, 3, mp3, inp)));
            check("det4", int'(det4), int'(en && !load && mmatch(q4, 4, mp4, inp)));
        end
`ifdef SEQ_DET_COUNT_EN
        check("count3", int'(cnt3), reset ? c3 : 0);
        check("count4", int'(cnt4), reset ? c4 : 0);
`endif
    end

    // One bit time: drive just after posedge, then check the literals just after negedge (x<0 = don't care).
    task automatic step(input bit b, input bit e, input bit ld, input int x3, input int x4);
        @(posedge clk); #1;
        inp = b; en = e; load = ld;
        @(negedge clk); #1;
        if (x3 >= 0) check("lit_det3", int'(det3), x3);
        if (x4 >= 0) check("lit_det4", int'(det4), x4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; inp = 1'b0; en = 1'b0; overlap = 1'b0; load = 1'b0;
        p3 = 3'b001; p4 = 4'b0101;
        repeat (3) @(negedge clk);
        #1;
        check("lit_reset_det3", int'(det3), 0);
        check("lit_reset_det4", int'(det4), 0);
        #1 reset = 1'b1;

        // T1: default pattern 001, non-overlapping.
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 1);

        // T2: 4-bit pattern 0101, first overlapping and then non-overlapping.
        overlap = 1'b1; p3 = 3'b001; p4 = 4'b0101;
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1); step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        overlap = 1'b0;
        step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1); step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0);

        // T3: en=0 holds the state.
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);

        // T4: a load mid-stream discards both the history and that cycle's bit.
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        p3 = 3'b110;
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(0, 1, 0, 1, 0);

        // Overlap with suffix/prefix reuse: pattern 101.
        p3 = 3'b101; overlap = 1'b1;
        step(0, 1, 1, 0, -1);
        step(1, 1, 0, 0, -1); step(0, 1, 0, 0, -1); step(1, 1, 0, 1, -1);
        step(0, 1, 0, 0, -1); step(1, 1, 0, 1, -1);
        overlap = 1'b0;

        // T5: asynchronous reset mid-sequence.
        p3 = 3'b001;
        step(0, 1, 1, 0, -1);
        step(0, 1, 0, 0, -1); step(0, 1, 0, 0, -1);
        @(posedge clk); #1;
        inp = 1'b1; en = 1'b1; load = 1'b0;
        #1 check("lit_pre_reset_det3", int'(det3), 1);
        #1 reset = 1'b0;
        #1 check("lit_async_reset_det3", int'(det3), 0);
        @(negedge clk); #2 reset = 1'b1;
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 1, 0, 1, 0);

        // T6: 20 non-overlapping 001 matches; the count saturates, then load clears it.
        p3 = 3'b001; p4 = 4'b1001;
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
`ifdef SEQ_DET_COUNT_EN
            check("lit_count3", int'(cnt3), (i < 15) ? i : 15);
`endif
            step(0, 1, 0, 0, -1);
            step(0, 1, 0, 0, -1);
            step(1, 1, 0, 1, -1);
        end
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
`ifdef SEQ_DET_COUNT_EN
        check("lit_count3_after_load", int'(cnt3), 0);
`endif

        // Pseudo-random mixed traffic, checked against the model only.
        for (int i = 0; i < 120; i++) begin
            overlap = 1'($urandom);
            p3 = 3'($urandom);
            p4 = 4'($urandom);
            step(1'($urandom), ($urandom % 4) != 0, ($urandom % 20) == 0, -1, -1);
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
